// File: rtl/adder_accum_pkg.sv
// Shared types and helpers for the four-lane adder frame accumulator.
// Optional saturation is enabled with `define ADDER_ACCUM_SAT_EN.
package adder_accum_pkg;

   localparam int DIN_W_DEF = 64;
   localparam int ACC_W_DEF = 72;
   localparam int LEN_W_DEF = 16;

   typedef enum logic {
      ST_IDLE,
      ST_ACC
   } state_e;

   typedef struct packed {
      logic                 cy;
      logic [ACC_W_DEF-1:0] sum;
   } add_res_t;

   // A frame length of zero behaves as a single-beat frame.
   function automatic logic [LEN_W_DEF-1:0] max1(
      input logic [LEN_W_DEF-1:0] len
   );
      return (len == '0) ? LEN_W_DEF'(1) : len;
   endfunction

   // Unsigned add reporting carry out; saturates when enabled.
   function automatic add_res_t acc_add(
      input logic [ACC_W_DEF-1:0] a,
      input logic [ACC_W_DEF-1:0] b
   );
      add_res_t             r;
      logic [ACC_W_DEF:0]   s;
      s     = {1'b0, a} + {1'b0, b};
      r.cy  = s[ACC_W_DEF];
      r.sum = s[ACC_W_DEF-1:0];
`ifdef ADDER_ACCUM_SAT_EN
      if (r.cy) r.sum = '1;
`endif
      return r;
   endfunction

endpackage

// File: rtl/adder_accum_outreg.sv
// One-entry valid/ready output slot for completed frame sums.
// A load that finds the slot full and not draining is dropped.
module adder_accum_outreg
   import adder_accum_pkg::*;
#(
   parameter int W = ACC_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ovf_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         ovf_o,
   output logic         valid_o,
   output logic         drop_o
);

   logic [W-1:0] data_q;
   logic         ovf_q;
   logic         valid_q;
   logic         drop_q;
   logic         free;

   assign free = !valid_q || ready_i;

   // Slot register: reload on free slot, clear on accept, flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= load_i && !free;
         if (load_i && free) begin
            data_q  <= data_i;
            ovf_q   <= ovf_i;
            valid_q <= 1'b1;
         end else if (ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data_o  = data_q;
   assign ovf_o   = ovf_q;
   assign valid_o = valid_q;
   assign drop_o  = drop_q;

endmodule

// File: rtl/adder_case4_accum.sv
// Accumulates frame_len partial-sum beats into one wide frame sum.
// Build with ADDER_ACCUM_SAT_EN to saturate instead of wrapping.
module adder_case4_accum
   import adder_accum_pkg::*;
#(
   parameter int DIN_W = DIN_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIN_W-1:0] din,
   input  logic             din_tvalid,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             clr,
   output logic [ACC_W-1:0] dout,
   output logic             dout_ovf,
   output logic             dout_tvalid,
   input  logic             dout_tready,
   output logic             frame_drop,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] din_ext;
   logic [ACC_W-1:0] sum;
   logic             cy;
   logic [LEN_W-1:0] len_new;
   logic [LEN_W-1:0] cnt_inc;
   add_res_t         add_r;

   logic             cmpl;
   logic [ACC_W-1:0] cmpl_sum;
   logic             cmpl_ovf;

   // Helpers in the package are sized for the default widths.
   assign din_ext = ACC_W'(din);
   assign add_r   = acc_add(ACC_W_DEF'(acc_q), ACC_W_DEF'(din_ext));
   assign sum     = ACC_W'(add_r.sum);
   assign cy      = add_r.cy;
   assign len_new = LEN_W'(max1(LEN_W_DEF'(frame_len)));
   assign cnt_inc = cnt_q + LEN_W'(1);

   // Frame state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, accumulation and frame completion.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      ovf_d    = ovf_q;
      cmpl     = 1'b0;
      cmpl_sum = acc_q;
      cmpl_ovf = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (din_tvalid && !clr) begin
               len_d = len_new;
               acc_d = din_ext;
               cnt_d = LEN_W'(1);
               ovf_d = 1'b0;
               if (len_new == LEN_W'(1)) begin
                  cmpl     = 1'b1;
                  cmpl_sum = din_ext;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            if (clr) begin
               state_d = ST_IDLE;
            end else if (din_tvalid) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  cmpl     = 1'b1;
                  cmpl_sum = sum;
                  cmpl_ovf = ovf_q | cy;
                  state_d  = ST_IDLE;
               end else begin
                  acc_d = sum;
                  ovf_d = ovf_q | cy;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   adder_accum_outreg #(
      .W (ACC_W)
   ) u_outreg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (cmpl),
      .data_i  (cmpl_sum),
      .ovf_i   (cmpl_ovf),
      .ready_i (dout_tready),
      .data_o  (dout),
      .ovf_o   (dout_ovf),
      .valid_o (dout_tvalid),
      .drop_o  (frame_drop)
   );

   assign busy = (state_q == ST_ACC);

endmodule

// File: tb/tb_adder_case4_accum.sv
// Directed bench for adder_case4_accum with hand-computed frame sums.
// Expects the saturating result when ADDER_ACCUM_SAT_EN is defined.
module tb_adder_case4_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] din = '0;
   logic        din_tvalid = 1'b0;
   logic [15:0] frame_len = '0;
   logic        clr = 1'b0;
   logic [71:0] dout;
   logic        dout_ovf;
   logic        dout_tvalid;
   logic        dout_tready = 1'b1;
   logic        frame_drop;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [71:0] big_exp;

   adder_case4_accum dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_tvalid  (din_tvalid),
      .frame_len   (frame_len),
      .clr         (clr),
      .dout        (dout),
      .dout_ovf    (dout_ovf),
      .dout_tvalid (dout_tvalid),
      .dout_tready (dout_tready),
      .frame_drop  (frame_drop),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock; outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d);
      din        = d;
      din_tvalid = 1'b1;
      step();
      din_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      din_tvalid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      step();
      chk("rst_dout", dout, 72'd0);
      chk("rst_valid", {71'd0, dout_tvalid}, 72'd0);
      chk("rst_ovf", {71'd0, dout_ovf}, 72'd0);
      chk("rst_drop", {71'd0, frame_drop}, 72'd0);
      chk("rst_busy", {71'd0, busy}, 72'd0);
      #2 rst_n = 1'b1;
      step();

      // Four back-to-back beats.
      frame_len = 16'd4;
      beat(64'd1);
      chk("t1_busy", {71'd0, busy}, 72'd1);
      chk("t1_novalid", {71'd0, dout_tvalid}, 72'd0);
      beat(64'd2);
      beat(64'd3);
      beat(64'd4);
      chk("t1_valid", {71'd0, dout_tvalid}, 72'd1);
      chk("t1_dout", dout, 72'd10);
      chk("t1_ovf", {71'd0, dout_ovf}, 72'd0);
      chk("t1_idle", {71'd0, busy}, 72'd0);
      idle(1);
      chk("t1_onecyc", {71'd0, dout_tvalid}, 72'd0);

      // Zero length acts as one; then gapped three-beat frame.
      frame_len = 16'd0;
      beat(64'h5);
      chk("t2_valid", {71'd0, dout_tvalid}, 72'd1);
      chk("t2_dout", dout, 72'd5);
      idle(1);
      frame_len = 16'd3;
      beat(64'd2);
      idle(2);
      beat(64'd4);
      idle(2);
      chk("t2_wait", {71'd0, dout_tvalid}, 72'd0);
      beat(64'd6);
      chk("t2b_valid", {71'd0, dout_tvalid}, 72'd1);
      chk("t2b_dout", dout, 72'd12);
      idle(1);

      // Backpressure: second single-beat frame is dropped.
      dout_tready = 1'b0;
      frame_len = 16'd1;
      beat(64'd7);
      chk("t3_dout", dout, 72'd7);
      chk("t3_nodrop", {71'd0, frame_drop}, 72'd0);
      beat(64'd9);
      chk("t3_drop", {71'd0, frame_drop}, 72'd1);
      chk("t3_hold", dout, 72'd7);
      idle(1);
      chk("t3_droppulse", {71'd0, frame_drop}, 72'd0);
      chk("t3_valid", {71'd0, dout_tvalid}, 72'd1);
      dout_tready = 1'b1;
      idle(1);
      chk("t3_accept", {71'd0, dout_tvalid}, 72'd0);
      chk("t3_keep", dout, 72'd7);

      // Overflow over 512 all-ones beats.
      frame_len = 16'd512;
      for (int i = 0; i < 512; i++) beat(64'hFFFF_FFFF_FFFF_FFFF);
`ifdef ADDER_ACCUM_SAT_EN
      big_exp = {72{1'b1}};
`else
      big_exp = 72'hFF_FFFF_FFFF_FFFF_FE00;
`endif
      chk("t4_valid", {71'd0, dout_tvalid}, 72'd1);
      chk("t4_ovf", {71'd0, dout_ovf}, 72'd1);
      chk("t4_dout", dout, big_exp);
      idle(1);

      // clr with a simultaneous beat aborts the frame.
      frame_len = 16'd4;
      beat(64'd1);
      beat(64'd2);
      clr = 1'b1;
      beat(64'd100);
      clr = 1'b0;
      chk("t5_busy", {71'd0, busy}, 72'd0);
      chk("t5_novalid", {71'd0, dout_tvalid}, 72'd0);
      beat(64'd3);
      chk("t5_restart", {71'd0, busy}, 72'd1);
      beat(64'd3);
      beat(64'd3);
      beat(64'd3);
      chk("t5_dout", dout, 72'd12);
      chk("t5_ovf", {71'd0, dout_ovf}, 72'd0);
      idle(1);

      // Asynchronous reset mid-frame.
      frame_len = 16'd2;
      beat(64'd5);
      chk("t6_busy", {71'd0, busy}, 72'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rstbusy", {71'd0, busy}, 72'd0);
      chk("t6_rstdout", dout, 72'd0);
      beat(64'd6);
      chk("t6_noout", {71'd0, dout_tvalid}, 72'd0);
      rst_n = 1'b1;
      idle(1);
      chk("t6_stillidle", {71'd0, busy}, 72'd0);
      beat(64'd5);
      beat(64'd6);
      chk("t6_valid", {71'd0, dout_tvalid}, 72'd1);
      chk("t6_dout", dout, 72'd11);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
